uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive byte buffer directly downstream of the UART receiver.
- Captures each completed byte (1-cycle complete pulse plus 8-bit data) into a first-word-fall-through FIFO.
- Presents the head byte to the 8051 serial-port SFR logic (SBUF read path) together with status flags: RI-style data-available, full, and sticky overrun.
- Decouples CPU read timing from line timing, so back-to-back bytes are not lost while the core services the interrupt.

Parameters:
- DEPTH, 8, number of byte entries; must be a power of 2, minimum 2.
- ADDR_W, 3, pointer width; must equal log2(DEPTH).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_complete  input  1  one-cycle strobe from the receiver: i_data holds a valid byte.
- i_data  input  8  received byte; sampled only when i_complete=1.
- i_en  input  1  receive enable (SCON.REN); when 0, incoming strobes are discarded.
- i_rd  input  1  pop strobe from SBUF read; one byte popped per cycle it is high.
- i_clr_ovr  input  1  clears the sticky overrun flag.
- o_data  output  8  head byte; 8'h00 whenever o_empty=1.
- o_empty  output  1  FIFO holds 0 bytes.
- o_full  output  1  FIFO holds DEPTH bytes.
- o_count  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
- o_ri  output  1  receive-interrupt request; equals ~o_empty.
- o_overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Storage: DEPTH x 8 register array; write pointer wr_ptr and read pointer rd_ptr, each ADDR_W bits, both wrap modulo DEPTH; count register is ADDR_W+1 bits.
- Reset (i_rst=1 at a clock edge): wr_ptr=0, rd_ptr=0, count=0, overrun=0. Resulting outputs: o_empty=1, o_full=0, o_count=0, o_ri=0, o_overrun=0, o_data=8'h00. Array contents are not cleared. Reset has priority over all other inputs, including a simultaneous i_complete or i_rd, and aborts any in-progress push or pop.
- Push condition: i_complete & i_en & (~full | pop). On push, mem[wr_ptr] <= i_data and wr_ptr <= wr_ptr+1.
- Pop condition: i_rd & ~empty. On pop, rd_ptr <= rd_ptr+1.
- Count update: count <= count + push - pop. A simultaneous push and pop leaves count unchanged.
- Full and pop in the same cycle: push is allowed, since a slot frees that cycle. No overrun; count stays DEPTH; the new byte lands at the old wr_ptr.
- Empty and i_rd in the same cycle: the pop is ignored, with no underflow and no pointer change. If i_complete is also high, the push proceeds and count becomes 1.
- Full, no pop, i_complete & i_en: the byte is dropped, memory and pointers are unchanged, and overrun <= 1.
- i_complete with i_en=0: the byte is dropped and overrun is unaffected.
- Overrun flag: sticky until i_clr_ovr=1. If a set event and i_clr_ovr occur in the same cycle, set wins and overrun stays 1.
- Latency:
  - A byte strobed at edge N is visible on o_data, and o_empty/o_ri/o_count update, after edge N; i.e. one cycle of write-to-read latency.
  - A pop at edge N exposes the next entry on o_data after edge N.
- o_data is a combinational read of mem[rd_ptr], gated to 8'h00 when count=0.
- o_full = (count==DEPTH); o_empty = (count==0). Both are derived from count, not from pointer comparison.
- Ordering: strict FIFO. Bytes are popped in arrival order across any number of pointer wraps.
- No combinational path from i_complete or i_data to any output.

Test Plan:
- Reset, then push 8'hA5: o_empty=1 and o_data=00 before the edge; after the edge, o_data=A5, o_count=1, o_ri=1. Pop: o_empty=1, o_data=00.
- Push 8'h01..8'h08 back-to-back: o_full=1, o_count=8. Push 8'h09: o_overrun=1, count stays 8. Pop all 8: sequence reads 01..08, and 09 is never seen.
- With the FIFO full, assert i_complete (8'h55) and i_rd in the same cycle: o_overrun stays 0, o_count=8, head advances from 01 to 02, and 55 is read last.
- With the FIFO empty, assert i_rd and i_complete (8'h3C) together: count=1, o_data=3C, no pointer corruption. i_rd alone while empty: no change.
- Do 20 push/pop pairs of 8'h10+k with the FIFO holding 3 entries, forcing pointer wrap: output order is preserved. Then i_clr_ovr together with an overflow event: o_overrun=1. i_clr_ovr alone: o_overrun=0.
- Assert i_rst while holding 5 bytes with i_complete high: o_count=0, o_empty=1, o_overrun=0, and the strobed byte is not stored. Push with i_en=0: no change.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receive byte buffer that sits directly after the UART receiver.
//            Each completed byte is captured into a first-word-fall-through
//            FIFO. The head byte and the status flags (data-available,
//            full, sticky overrun) are presented to the serial-port SFR
//            read path.
// Ports    : i_clk, i_rst    - clock; synchronous active-high reset
//            i_complete      - 1-cycle strobe: i_data holds a valid byte
//            i_data[7:0]     - received byte
//            i_en            - receive enable; strobes are discarded when low
//            i_rd            - pop strobe, one byte per cycle while high
//            i_clr_ovr       - clears the sticky overrun flag
//            o_data[7:0]     - head byte; 8'h00 while empty
//            o_empty/o_full  - occupancy flags, derived from the count
//            o_count         - number of stored bytes, 0..DEPTH
//            o_ri            - receive-interrupt request (= ~o_empty)
//            o_overrun       - sticky: a byte was dropped because FIFO full
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_complete,
   input  logic [7:0]        i_data,
   input  logic              i_en,
   input  logic              i_rd,
   input  logic              i_clr_ovr,
   output logic [7:0]        o_data,
   output logic              o_empty,
   output logic              o_full,
   output logic [ADDR_W:0]   o_count,
   output logic              o_ri,
   output logic              o_overrun
);

   localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   c_CNT_ONE = (ADDR_W+1)'(1);

   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_overrun;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_DEPTH);
   assign w_pop   = i_rd & ~w_empty;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign w_push  = i_complete & i_en & (~w_full | w_pop);
   assign w_drop  = i_complete & i_en & w_full & ~w_pop;

   // Storage is deliberately not reset; stale contents are masked by count.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_CNT_ONE;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - c_CNT_ONE;
         end
         // A drop in the same cycle as a clear keeps the flag set.
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (i_clr_ovr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign o_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign o_empty   = w_empty;
   assign o_full    = w_full;
   assign o_count   = r_count;
   assign o_ri      = ~w_empty;
   assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed testbench for uart_rx_fifo. A queue-based model of the
//            buffer is compared against the DUT outputs every cycle, and
//            hand-computed literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   logic              clk;
   logic              rst;
   logic              complete;
   logic [7:0]        data;
   logic              en;
   logic              rd;
   logic              clr_ovr;
   logic [7:0]        o_data;
   logic              o_empty;
   logic              o_full;
   logic [ADDR_W:0]   o_count;
   logic              o_ri;
   logic              o_overrun;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model state: the stored bytes in arrival order, plus the sticky flag.
   logic [7:0] m_q [$];
   bit         m_ovr = 1'b0;

   uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_complete (complete),
      .i_data     (data),
      .i_en       (en),
      .i_rd       (rd),
      .i_clr_ovr  (clr_ovr),
      .o_data     (o_data),
      .o_empty    (o_empty),
      .o_full     (o_full),
      .o_count    (o_count),
      .o_ri       (o_ri),
      .o_overrun  (o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model, evaluated on the same edge as the DUT.
   always @(posedge clk) begin
      bit do_pop;
      bit do_push;
      bit drop;
      if (rst) begin
         m_q.delete();
         m_ovr = 1'b0;
      end else begin
         do_pop  = rd && (m_q.size() > 0);
         do_push = 1'b0;
         drop    = 1'b0;
         if (complete && en) begin
            if (m_q.size() < DEPTH || do_pop) do_push = 1'b1;
            else                              drop    = 1'b1;
         end
         if (do_pop)  void'(m_q.pop_front());
         if (do_push) m_q.push_back(data);
         if (drop)         m_ovr = 1'b1;
         else if (clr_ovr) m_ovr = 1'b0;
      end
   end

   // Compare process: outputs are stable mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_data",    {24'h0, o_data},  (m_q.size() > 0) ? {24'h0, m_q[0]} : 32'h0);
         chk("m_count",   {28'h0, o_count}, m_q.size());
         chk("m_empty",   {31'h0, o_empty}, (m_q.size() == 0) ? 32'd1 : 32'd0);
         chk("m_full",    {31'h0, o_full},  (m_q.size() == DEPTH) ? 32'd1 : 32'd0);
         chk("m_ri",      {31'h0, o_ri},    (m_q.size() != 0) ? 32'd1 : 32'd0);
         chk("m_overrun", {31'h0, o_overrun}, {31'h0, m_ovr});
      end
   end

   // One clock with the given inputs, then all strobes return low.
   task automatic step(input bit c, input logic [7:0] d, input bit r,
                       input bit clr, input bit rs);
      complete = c;
      data     = d;
      rd       = r;
      clr_ovr  = clr;
      rst      = rs;
      @(posedge clk);
      #1;
      complete = 1'b0;
      rd       = 1'b0;
      clr_ovr  = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      step(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; complete = 1'b0; data = 8'h00; en = 1'b1; rd = 1'b0; clr_ovr = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk_en = 1'b1;
      chk("rst_empty", {31'h0, o_empty}, 32'd1);
      chk("rst_count", {28'h0, o_count}, 32'd0);
      chk("rst_ovr",   {31'h0, o_overrun}, 32'd0);
      chk("rst_data",  {24'h0, o_data}, 32'h00);

      // Single byte: no combinational path from the strobe to the outputs.
      complete = 1'b1; data = 8'hA5;
      #2;
      chk("pre_edge_empty", {31'h0, o_empty}, 32'd1);
      chk("pre_edge_data",  {24'h0, o_data}, 32'h00);
      step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      chk("a5_data",  {24'h0, o_data}, 32'hA5);
      chk("a5_count", {28'h0, o_count}, 32'd1);
      chk("a5_ri",    {31'h0, o_ri}, 32'd1);
      pop();
      chk("a5_pop_empty", {31'h0, o_empty}, 32'd1);
      chk("a5_pop_data",  {24'h0, o_data}, 32'h00);

      // Fill, overflow, drain.
      for (int i = 1; i <= 8; i++) push(8'(i));
      chk("fill_full",  {31'h0, o_full}, 32'd1);
      chk("fill_count", {28'h0, o_count}, 32'd8);
      push(8'h09);
      chk("ovf_flag",  {31'h0, o_overrun}, 32'd1);
      chk("ovf_count", {28'h0, o_count}, 32'd8);
      for (int i = 1; i <= 8; i++) begin
         chk("drain_seq", {24'h0, o_data}, i);
         pop();
      end
      chk("drain_empty", {31'h0, o_empty}, 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("clr_ovr", {31'h0, o_overrun}, 32'd0);

      // Full with simultaneous push and pop.
      for (int i = 1; i <= 8; i++) push(8'(i));
      step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      chk("fullpp_ovr",   {31'h0, o_overrun}, 32'd0);
      chk("fullpp_count", {28'h0, o_count}, 32'd8);
      chk("fullpp_head",  {24'h0, o_data}, 32'h02);
      for (int i = 2; i <= 8; i++) pop();
      chk("fullpp_last",  {24'h0, o_data}, 32'h55);
      pop();

      // Empty with simultaneous push and pop; then pop while empty.
      step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
      chk("emptypp_count", {28'h0, o_count}, 32'd1);
      chk("emptypp_data",  {24'h0, o_data}, 32'h3C);
      pop();
      pop();
      chk("underflow_count", {28'h0, o_count}, 32'd0);

      // Pointer wrap with three entries resident.
      push(8'hA0); push(8'hA1); push(8'hA2);
      for (int k = 0; k < 20; k++) begin
         chk("wrap_head", {24'h0, o_data}, (k < 3) ? (32'hA0 + k) : (32'h10 + k - 3));
         step(1'b1, 8'(8'h10 + k), 1'b1, 1'b0, 1'b0);
      end
      chk("wrap_count", {28'h0, o_count}, 32'd3);
      chk("wrap_tail_head", {24'h0, o_data}, 32'h21);
      for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
      step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
      chk("set_beats_clr", {31'h0, o_overrun}, 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("clr_alone", {31'h0, o_overrun}, 32'd0);

      // Reset with 5 bytes held, overrun set, and a strobe in flight.
      push(8'h78);
      pop(); pop(); pop();
      chk("pre_rst_count", {28'h0, o_count}, 32'd5);
      step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
      chk("rst5_count", {28'h0, o_count}, 32'd0);
      chk("rst5_empty", {31'h0, o_empty}, 32'd1);
      chk("rst5_ovr",   {31'h0, o_overrun}, 32'd0);
      chk("rst5_data",  {24'h0, o_data}, 32'h00);

      // Receive disabled: strobes ignored, even when full.
      en = 1'b0;
      push(8'h42);
      chk("dis_count", {28'h0, o_count}, 32'd0);
      en = 1'b1;
      for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
      en = 1'b0;
      push(8'h43);
      chk("dis_full_ovr",   {31'h0, o_overrun}, 32'd0);
      chk("dis_full_count", {28'h0, o_count}, 32'd8);
      chk("dis_full_head",  {24'h0, o_data}, 32'hC0);
      en = 1'b1;

      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
